// File: rtl/om_blend_select.sv
// Per-channel blend equation select feeding a 2-entry elastic output buffer.
// Buffer state is fully cleared by the asynchronous active-low reset.
module om_blend_select #(
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [2:0]           mode_rgb,
  input  logic [2:0]           mode_a,
  input  logic [31:0]          funcadd_in,
  input  logic [31:0]          min_in,
  input  logic [31:0]          max_in,
  input  logic [31:0]          logic_in,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [31:0]          color_out,
  output logic [TAG_WIDTH-1:0] tag_out,
  output logic                 mode_err,
  output logic [31:0]          pixel_count
);

  function automatic logic [7:0] pick(
    input logic [2:0] m,
    input logic [7:0] fa,
    input logic [7:0] mn,
    input logic [7:0] mx,
    input logic [7:0] lo
  );
    logic [7:0] r;
    case (m)
      3'd0, 3'd1, 3'd2: r = fa;
      3'd3:             r = mn;
      3'd4:             r = mx;
      3'd5:             r = lo;
      default:          r = 8'h00;
    endcase
    return r;
  endfunction

  logic [31:0]          sel;
  logic [31:0]          buf_color [2];
  logic [TAG_WIDTH-1:0] buf_tag   [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;
  logic                 push;
  logic                 pop;
  logic                 bad_mode;

  always_comb begin
    sel = '0;
    for (int i = 0; i < 4; i++) begin
      sel[i*8 +: 8] = pick((i == 3) ? mode_a : mode_rgb,
                           funcadd_in[i*8 +: 8],
                           min_in[i*8 +: 8],
                           max_in[i*8 +: 8],
                           logic_in[i*8 +: 8]);
    end
  end

  // ready_in is derived from registered count only
  assign ready_in  = (count != 2'd2);
  assign valid_out = (count != 2'd0);
  assign color_out = buf_color[rd_ptr];
  assign tag_out   = buf_tag[rd_ptr];

  assign push     = valid_in && ready_in;
  assign pop      = valid_out && ready_out;
  assign bad_mode = (mode_rgb[2:1] == 2'b11) || (mode_a[2:1] == 2'b11);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_color[i] <= '0;
        buf_tag[i]   <= '0;
      end
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      mode_err    <= 1'b0;
      pixel_count <= '0;
    end else begin
      if (push) begin
        buf_color[wr_ptr] <= sel;
        buf_tag[wr_ptr]   <= tag_in;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr      <= ~rd_ptr;
        pixel_count <= pixel_count + 32'd1;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push && bad_mode) mode_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_om_blend_select.sv
// Randomized and directed bench for om_blend_select.
// Expected values come from a queue-based model of the buffer.
module tb_om_blend_select;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic [2:0]  mode_rgb;
  logic [2:0]  mode_a;
  logic [31:0] funcadd_in;
  logic [31:0] min_in;
  logic [31:0] max_in;
  logic [31:0] logic_in;
  logic [7:0]  tag_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] color_out;
  logic [7:0]  tag_out;
  logic        mode_err;
  logic [31:0] pixel_count;

  om_blend_select #(.TAG_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in),
    .mode_rgb(mode_rgb), .mode_a(mode_a),
    .funcadd_in(funcadd_in), .min_in(min_in),
    .max_in(max_in), .logic_in(logic_in),
    .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .color_out(color_out), .tag_out(tag_out),
    .mode_err(mode_err), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] color;
    logic [7:0]  tag;
  } pix_t;

  pix_t        q[$];
  logic        m_err;
  logic [31:0] m_cnt;
  bit          acc;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_color(
    logic [2:0] mr, logic [2:0] ma,
    logic [31:0] fa, logic [31:0] mn,
    logic [31:0] mx, logic [31:0] lo
  );
    logic [31:0] r;
    logic [2:0]  m;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      m = (i == 3) ? ma : mr;
      if (m <= 3'd2)      r[i*8 +: 8] = fa[i*8 +: 8];
      else if (m == 3'd3) r[i*8 +: 8] = mn[i*8 +: 8];
      else if (m == 3'd4) r[i*8 +: 8] = mx[i*8 +: 8];
      else if (m == 3'd5) r[i*8 +: 8] = lo[i*8 +: 8];
      else                r[i*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

  task automatic compare_all();
    check("ready_in", {31'd0, ready_in}, {31'd0, q.size() < 2});
    check("valid_out", {31'd0, valid_out}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("color_out", color_out, q[0].color);
      check("tag_out", {24'd0, tag_out}, {24'd0, q[0].tag});
    end
    check("mode_err", {31'd0, mode_err}, {31'd0, m_err});
    check("pixel_count", pixel_count, m_cnt);
  endtask

  task automatic tick();
    bit   push;
    bit   pop;
    pix_t p;
    @(posedge clk);
    push = valid_in && (q.size() < 2);
    pop  = (q.size() != 0) && ready_out;
    acc  = push;
    if (pop) begin
      void'(q.pop_front());
      m_cnt++;
    end
    if (push) begin
      p.color = ref_color(mode_rgb, mode_a, funcadd_in,
                          min_in, max_in, logic_in);
      p.tag   = tag_in;
      q.push_back(p);
      if (mode_rgb >= 3'd6 || mode_a >= 3'd6) m_err = 1'b1;
    end
    @(negedge clk);
    compare_all();
  endtask

  logic [31:0] sweep_exp [4];
  logic [2:0]  sweep_mode [4];
  logic [7:0]  rx[$];
  logic [31:0] base;
  int          sent;

  initial begin
    sweep_mode = '{3'd0, 3'd3, 3'd4, 3'd5};
    sweep_exp  = '{32'h11223344, 32'h01020304,
                   32'hF1F2F3F4, 32'hA5A5A5A5};
    reset = 1'b0;
    valid_in = 0; ready_out = 0;
    mode_rgb = 0; mode_a = 0; tag_in = 0;
    funcadd_in = 32'h11223344; min_in = 32'h01020304;
    max_in = 32'hF1F2F3F4; logic_in = 32'hA5A5A5A5;
    m_err = 0; m_cnt = 0;
    #12;
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_ready_in", {31'd0, ready_in}, 32'd1);
    check("rst_color", color_out, 32'd0);
    check("rst_tag", {24'd0, tag_out}, 32'd0);
    check("rst_mode_err", {31'd0, mode_err}, 32'd0);
    check("rst_count", pixel_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // mode sweep, streaming
    ready_out = 1;
    valid_in  = 1;
    for (int k = 0; k < 4; k++) begin
      mode_rgb = sweep_mode[k];
      mode_a   = sweep_mode[k];
      tag_in   = 8'(k + 10);
      tick();
      check("sweep_color", color_out, sweep_exp[k]);
    end
    mode_rgb = 3'd4; mode_a = 3'd3;
    tick();
    check("split_maxmin", color_out, 32'h01F2F3F4);
    mode_rgb = 3'd7; mode_a = 3'd0;
    tick();
    check("split_resv", color_out, 32'h11000000);
    check("err_set", {31'd0, mode_err}, 32'd1);
    mode_rgb = 3'd0;
    tick();
    check("err_sticky", {31'd0, mode_err}, 32'd1);
    valid_in = 0;
    tick();
    tick();

    // backpressure
    base = m_cnt;
    ready_out = 0;
    valid_in  = 1;
    tag_in = 8'd1; tick();
    tag_in = 8'd2; tick();
    tag_in = 8'd3; tick();
    check("bp_ready_low", {31'd0, ready_in}, 32'd0);
    check("bp_not_acc", {31'd0, acc}, 32'd0);
    ready_out = 1;
    rx.delete();
    for (int i = 0; i < 6; i++) begin
      if (valid_out) rx.push_back(tag_out);
      tick();
      if (acc) valid_in = 0;
    end
    check("bp_rx_size", rx.size(), 32'd3);
    for (int i = 0; i < rx.size() && i < 3; i++)
      check("bp_order", {24'd0, rx[i]}, i + 1);
    check("bp_count", m_cnt - base, 32'd3);
    check("bp_count_dut", pixel_count - base, 32'd3);

    // continuous push/pop at count 1
    base = pixel_count;
    rx.delete();
    sent = 0;
    valid_in = 1;
    mode_rgb = 0; mode_a = 0;
    for (int i = 0; i < 300 && sent < 100; i++) begin
      tag_in = 8'(sent);
      if (valid_out) rx.push_back(tag_out);
      check("stream_ready", {31'd0, ready_in}, 32'd1);
      tick();
      if (acc) sent++;
    end
    check("stream_sent", sent, 32'd100);
    valid_in = 0;
    for (int i = 0; i < 3; i++) begin
      if (valid_out) rx.push_back(tag_out);
      tick();
    end
    check("stream_rx", rx.size(), 32'd100);
    for (int i = 0; i < rx.size(); i++)
      check("stream_order", {24'd0, rx[i]}, 32'(8'(i)));
    check("stream_count", pixel_count - base, 32'd100);

    // reset mid-stream
    ready_out = 0;
    valid_in  = 1;
    mode_rgb = 3'd6; tag_in = 8'h55; tick();
    mode_rgb = 3'd0; tag_in = 8'h66; tick();
    valid_in = 0;
    check("pre_rst_err", {31'd0, mode_err}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    check("mid_rst_ready", {31'd0, ready_in}, 32'd1);
    check("mid_rst_color", color_out, 32'd0);
    check("mid_rst_tag", {24'd0, tag_out}, 32'd0);
    check("mid_rst_err", {31'd0, mode_err}, 32'd0);
    check("mid_rst_count", pixel_count, 32'd0);
    q.delete();
    m_err = 0;
    m_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ready_out = 1;
    for (int i = 0; i < 3; i++) tick();

    // counter wrap
    force dut.pixel_count = 32'hFFFF_FFFE;
    #1 release dut.pixel_count;
    m_cnt = 32'hFFFF_FFFE;
    #1 check("wrap_preload", pixel_count, 32'hFFFF_FFFE);
    valid_in = 1;
    tag_in = 8'hA0; tick();
    tag_in = 8'hA1; tick();
    check("wrap_ffff", pixel_count, 32'hFFFF_FFFF);
    valid_in = 0;
    tick();
    check("wrap_zero", pixel_count, 32'd0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      valid_in   = ($urandom_range(0, 3) != 0);
      ready_out  = ($urandom_range(0, 9) < 6);
      mode_rgb   = 3'($urandom_range(0, 7));
      mode_a     = 3'($urandom_range(0, 7));
      funcadd_in = $urandom;
      min_in     = $urandom;
      max_in     = $urandom;
      logic_in   = $urandom;
      tag_in     = 8'($urandom);
      tick();
    end
    valid_in  = 0;
    ready_out = 1;
    for (int i = 0; i < 3; i++) tick();
    check("drain_empty", {31'd0, valid_out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/om_blend_select.md
# om_blend_select

Per-channel blend equation selector and output buffer for the OM blend pipeline. It sits directly downstream of the blend min/max unit and the parallel func-add and logic-op units, and consumes their per-pixel results. For each channel it picks the result required by the programmed RGB and alpha equations. Results go into a 2-entry elastic output buffer with valid/ready handshakes on both sides, in front of the OM write-back stage.

## Interface
Parameters:
- TAG_WIDTH, default 8: width of the per-pixel sideband tag carried through unchanged.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  1  input pixel valid.
- ready_in  output  1  block can accept an input pixel this cycle.
- mode_rgb  input  3  equation for channels [23:0]: 0 ADD, 1 SUB, 2 REV_SUB, 3 MIN, 4 MAX, 5 LOGICOP, 6-7 reserved.
- mode_a  input  3  equation for channel [31:24], same encoding.
- funcadd_in  input  32  ARGB result of the func-add unit (add, sub or rev-sub already applied upstream).
- min_in  input  32  ARGB per-channel min from the min/max unit.
- max_in  input  32  ARGB per-channel max from the min/max unit.
- logic_in  input  32  ARGB logic-op result.
- tag_in  input  TAG_WIDTH  sideband tag.
- valid_out  output  1  output pixel valid.
- ready_out  input  1  downstream accepts this cycle.
- color_out  output  32  selected ARGB color.
- tag_out  output  TAG_WIDTH  tag associated with color_out.
- mode_err  output  1  sticky flag: a reserved mode code was accepted.
- pixel_count  output  32  count of pixels delivered downstream.

## Operation
- Select (combinational, per transfer):
  - RGB channels [23:16], [15:8], [7:0] use mode_rgb.
  - Alpha [31:24] uses mode_a.
  - Codes 0/1/2 select funcadd_in; 3 selects min_in; 4 selects max_in; 5 selects logic_in; 6/7 force the channel to 8'h00.
- Input transfer: valid_in && ready_in. All inputs are sampled only on a transfer.
- Output buffer: 2-entry FIFO of {color, tag} with a count register in the range 0..2.
  - ready_in = (count < 2). It depends on registered state only and has no combinational path from ready_out.
  - Head entry drives color_out/tag_out. valid_out = (count != 0).
  - Output transfer: valid_out && ready_out. Head pops and the next entry advances.
- Simultaneous push and pop:
  - count 1: count stays 1; the new entry becomes head next cycle.
  - count 0: only a push is possible.
  - count 2: no push, since ready_in = 0.
- Ordering is strictly FIFO. No pixel is dropped or duplicated.
- mode_err is set on any input transfer where mode_rgb or mode_a is 6 or 7. It is cleared only by reset.
- pixel_count increments by 1 on each output transfer. It wraps from 32'hFFFF_FFFF to 0.
- Reset asserted (reset = 0), asynchronously:
  - count = 0, so valid_out = 0 and ready_in = 1.
  - color_out = 0, tag_out = 0, mode_err = 0, pixel_count = 0.
  - Buffer contents are cleared to 0.
- Reset asserted mid-stream discards all buffered pixels. No partial state survives.
- Outputs hold stable while valid_out && !ready_out.

## Timing
- Latency: a pixel accepted in cycle N is visible on valid_out/color_out in cycle N+1, when the buffer was empty or popped in cycle N.
- Throughput: 1 pixel/cycle while ready_out stays high. Count never exceeds 1 and ready_in stays 1.
- Backpressure:
  - With ready_out low, two pixels are absorbed and ready_in drops in the cycle after the second accept.
  - ready_in returns high the cycle after the first pop.
- mode_err and pixel_count update on the clock edge of the qualifying transfer. Each is visible the next cycle.
- Reset deassertion is synchronized externally. The first transfer is allowed on the first clock edge with reset = 1.

## Test plan
- Mode sweep, ready_out = 1:
  - Stimulus: funcadd_in=32'h11223344, min_in=32'h01020304, max_in=32'hF1F2F3F4, logic_in=32'hA5A5A5A5.
  - mode_rgb/mode_a = 0,3,4,5 gives color_out 32'h11223344, 32'h01020304, 32'hF1F2F3F4, 32'hA5A5A5A5, each one cycle after accept.
- Split modes:
  - mode_rgb = 4 (MAX), mode_a = 3 (MIN), with the sweep inputs, gives color_out = 32'h01F2F3F4.
  - mode_rgb = 7, mode_a = 0 gives color_out = 32'h11000000 and mode_err = 1 next cycle; mode_err stays 1 through later valid modes.
- Backpressure, ready_out = 0:
  - Push tags 1,2,3 on consecutive cycles: tags 1 and 2 are accepted and ready_in = 0 while 3 is held.
  - Raise ready_out: tags out in order 1,2,3 with no gaps once streaming.
  - pixel_count = 3 afterwards.
- Simultaneous push/pop at count 1 with continuous valid_in and ready_out:
  - 100 pixels stream at 1/cycle with ready_in constantly 1.
  - Tags are output in order and pixel_count = 100.
- Reset mid-stream:
  - With 2 pixels buffered and mode_err = 1, assert reset asynchronously between clock edges.
  - valid_out = 0, ready_in = 1, color_out = 0, tag_out = 0, mode_err = 0 and pixel_count = 0 immediately.
  - No stale pixel appears after deassertion.
- Counter wrap:
  - Preload pixel_count to 32'hFFFF_FFFE via force, then deliver 2 pixels: the count reads 32'hFFFF_FFFF, then 0.
